cgra_col_obi_bridge: RTL and testbench

- Per-column master adapter between one CGRA column's load/store port and one master port of the external crossbar (one instance per column, 4 instances).
- Converts a valid/ready column request stream into OBI req/gnt/rvalid transactions and tracks outstanding reads/writes.
- Buffers responses in a small FIFO so the column can stall without violating OBI, which cannot back-pressure rvalid.
- Answers requests outside a legal address window locally with an error response; these generate no OBI traffic.

---
 rtl/cgra_col_obi_bridge.sv | 87 ++++++++
 tb/tb_cgra_col_obi_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_col_obi_bridge.sv
// cgra_col_obi_bridge: column load/store stream to OBI master adapter with credit-reserved response FIFO
module cgra_col_obi_bridge #(
  parameter int          RSP_FIFO_DEPTH = 2,
  parameter logic [31:0] WIN_START      = 32'h0000_0000,
  parameter logic [31:0] WIN_END        = 32'h0010_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        col_req_valid_i,
  output logic        col_req_ready_o,
  input  logic        col_req_we_i,
  input  logic [3:0]  col_req_be_i,
  input  logic [31:0] col_req_addr_i,
  input  logic [31:0] col_req_wdata_i,
  output logic        col_rsp_valid_o,
  input  logic        col_rsp_ready_i,
  output logic [31:0] col_rsp_rdata_o,
  output logic        col_rsp_err_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  output logic        busy_o
);
  localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int PW = RSP_FIFO_DEPTH > 1 ? $clog2(RSP_FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] outstanding, count;
  logic [CW:0] reserved;
  logic [PW-1:0] wptr, rptr;
  logic req_we;
  logic [3:0] req_be;
  logic [31:0] req_addr, req_wdata;
  logic [32:0] mem [RSP_FIFO_DEPTH];
  logic accept, in_win, gnt, rv_push, err_push, push, pop;
  always_comb begin
    reserved = {1'b0, outstanding} + {1'b0, count} + (CW+1)'(state == REQ);
    // single unsigned compare covers both window bounds
    in_win = (col_req_addr_i - WIN_START) < (WIN_END - WIN_START);
    col_req_ready_o = !rst_i && state == IDLE && reserved < (CW+1)'(RSP_FIFO_DEPTH);
    accept = col_req_valid_i && col_req_ready_o;
    gnt = state == REQ && obi_gnt_i;
    rv_push = obi_rvalid_i && outstanding != '0;
    err_push = state == ERR && outstanding == '0;
    push = rv_push || err_push;
    col_rsp_valid_o = count != '0;
    pop = col_rsp_valid_o && col_rsp_ready_i;
    {col_rsp_rdata_o, col_rsp_err_o} = col_rsp_valid_o ? mem[rptr] : '0;
    obi_req_o = state == REQ;
    obi_addr_o = obi_req_o ? req_addr : '0;
    obi_we_o = obi_req_o && req_we;
    obi_be_o = obi_req_o ? req_be : '0;
    obi_wdata_o = obi_req_o ? req_wdata : '0;
    busy_o = state != IDLE || outstanding != '0 || col_rsp_valid_o;
    state_n = state == IDLE ? (accept ? (in_win ? REQ : ERR) : IDLE) :
              state == REQ  ? (obi_gnt_i ? IDLE : REQ) :
                              (outstanding == '0 ? IDLE : ERR);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      outstanding <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      req_we <= 1'b0;
      req_be <= '0;
      req_addr <= '0;
      req_wdata <= '0;
    end else begin
      state <= state_n;
      outstanding <= outstanding + CW'(gnt) - CW'(rv_push);
      count <= count + CW'(push) - CW'(pop);
      if (push) wptr <= wptr == PW'(RSP_FIFO_DEPTH - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == PW'(RSP_FIFO_DEPTH - 1) ? '0 : rptr + 1'b1;
      if (accept) {req_we, req_be, req_addr, req_wdata} <= {col_req_we_i, col_req_be_i, col_req_addr_i, col_req_wdata_i};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wptr] <= err_push ? {32'h0, 1'b1} : {obi_rdata_i, 1'b0};
  end
endmodule

// File: tb/tb_cgra_col_obi_bridge.sv
// tb_cgra_col_obi_bridge: directed scenarios plus randomized traffic against an in-order transaction model
module tb_cgra_col_obi_bridge;
  localparam int DEPTH = 2;
  localparam logic [31:0] WS = 32'h0000_0100;
  localparam logic [31:0] WE = 32'h0010_0000;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } oreq_t;
  logic clk = 1'b0;
  logic rst_i, col_req_valid_i, col_req_we_i, col_rsp_ready_i, obi_gnt_i, obi_rvalid_i;
  logic [3:0] col_req_be_i;
  logic [31:0] col_req_addr_i, col_req_wdata_i, obi_rdata_i;
  logic col_req_ready_o, col_rsp_valid_o, col_rsp_err_o, obi_req_o, obi_we_o, busy_o;
  logic [31:0] col_rsp_rdata_o, obi_addr_o, obi_wdata_o;
  logic [3:0] obi_be_o;
  int nerr = 0, nchk = 0;
  int issued = 0, n_acc = 0, n_grant = 0, idx = 0;
  int unsigned gnt_pct = 0, rv_pct = 0;
  bit auto_sl = 0, rnd_req = 0, acc_flag = 0, prev_hold = 0;
  logic [68:0] prev_obi;
  bit exp_err[$];
  oreq_t obi_exp[$];
  logic [31:0] rdq[$], sl_q[$];
  cgra_col_obi_bridge #(.RSP_FIFO_DEPTH(DEPTH), .WIN_START(WS), .WIN_END(WE)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .col_req_valid_i(col_req_valid_i), .col_req_ready_o(col_req_ready_o),
    .col_req_we_i(col_req_we_i), .col_req_be_i(col_req_be_i),
    .col_req_addr_i(col_req_addr_i), .col_req_wdata_i(col_req_wdata_i),
    .col_rsp_valid_o(col_rsp_valid_o), .col_rsp_ready_i(col_rsp_ready_i),
    .col_rsp_rdata_o(col_rsp_rdata_o), .col_rsp_err_o(col_rsp_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic bit in_win(input logic [31:0] a);
    return a >= WS && a < WE;
  endfunction
  function automatic logic [31:0] pick_addr();
    case ($urandom_range(7))
      0: return WS - 32'd4;
      1: return WS;
      2: return WE - 32'd4;
      3: return WE;
      4: return 32'hFFFF_FFFC;
      default: return WS + ($urandom_range(32'hFFFF) << 2);
    endcase
  endfunction
  function automatic logic [105:0] all_outs();
    return {col_req_ready_o, col_rsp_valid_o, col_rsp_rdata_o, col_rsp_err_o, obi_req_o,
            obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, busy_o};
  endfunction
  // Model: responses leave in acceptance order; reads/writes take OBI data in order, window misses give err
  task automatic monitor();
    oreq_t o;
    bit e;
    if (rst_i) begin
      exp_err.delete(); obi_exp.delete(); rdq.delete(); sl_q.delete();
      issued = 0; prev_hold = 0; acc_flag = 0;
      return;
    end
    if (prev_hold) check("obi_hold", {obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o}, {1'b1, prev_obi});
    if (obi_rvalid_i && issued > 0) begin
      rdq.push_back(obi_rdata_i);
      issued--;
    end
    if (obi_req_o && obi_gnt_i) begin
      n_grant++;
      issued++;
      if (auto_sl) sl_q.push_back(obi_we_o ? 32'h0 : $urandom);
      check("obi_expected", obi_exp.size() != 0, 1);
      if (obi_exp.size() != 0) begin
        o = obi_exp.pop_front();
        check("obi_fields", {obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o}, o);
      end
    end
    prev_hold = obi_req_o && !obi_gnt_i;
    prev_obi = {obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o};
    acc_flag = col_req_valid_i && col_req_ready_o;
    if (acc_flag) check("credit", exp_err.size() < DEPTH, 1);
    if (col_rsp_valid_o && col_rsp_ready_i) begin
      check("rsp_expected", exp_err.size() != 0, 1);
      if (exp_err.size() != 0) begin
        e = exp_err.pop_front();
        if (e) check("rsp_err", {col_rsp_err_o, col_rsp_rdata_o}, {1'b1, 32'h0});
        else begin
          check("rsp_source", rdq.size() != 0, 1);
          if (rdq.size() != 0) check("rsp_data", {col_rsp_err_o, col_rsp_rdata_o}, {1'b0, rdq.pop_front()});
        end
      end
    end
    if (acc_flag) begin
      n_acc++;
      exp_err.push_back(!in_win(col_req_addr_i));
      if (in_win(col_req_addr_i)) obi_exp.push_back({col_req_addr_i, col_req_we_i, col_req_be_i, col_req_wdata_i});
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (auto_sl) begin
      obi_gnt_i = $urandom_range(99) < gnt_pct;
      if (sl_q.size() != 0 && $urandom_range(99) < rv_pct) begin
        obi_rvalid_i = 1'b1;
        obi_rdata_i = sl_q.pop_front();
      end else begin
        obi_rvalid_i = 1'b0;
        obi_rdata_i = $urandom;
      end
    end
    if (rnd_req) begin
      if (!col_req_valid_i || acc_flag) begin
        col_req_valid_i = $urandom_range(99) < 60;
        col_req_we_i = 1'($urandom);
        col_req_be_i = 4'($urandom);
        col_req_addr_i = pick_addr();
        col_req_wdata_i = $urandom;
      end
      col_rsp_ready_i = $urandom_range(99) < 70;
    end
  endtask
  task automatic t3_run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (acc_flag) begin
        idx++;
        col_req_addr_i = 32'h110 + 32'(idx * 4);
        if (idx == 3) col_req_valid_i = 1'b0;
      end
    end
  endtask
  initial begin
    int g0, a0;
    rst_i = 1; col_req_valid_i = 0; col_req_we_i = 0; col_req_be_i = 0; col_req_addr_i = 0;
    col_req_wdata_i = 0; col_rsp_ready_i = 0; obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0;
    repeat (3) cyc();
    check("reset_outputs", all_outs(), 0);
    rst_i = 0;
    #1;
    check("reset_ready", {col_req_ready_o, busy_o}, 2'b10);
    // read with immediate grant and next-cycle rvalid
    col_rsp_ready_i = 1; col_req_valid_i = 1; col_req_we_i = 0; col_req_be_i = 4'hF;
    col_req_addr_i = 32'h100; obi_gnt_i = 1;
    cyc();
    col_req_valid_i = 0;
    check("t1_req", {obi_req_o, obi_addr_o, obi_we_o}, {1'b1, 32'h100, 1'b0});
    cyc();
    obi_gnt_i = 0; obi_rvalid_i = 1; obi_rdata_i = 32'hDEAD_BEEF;
    check("t1_req_once", {obi_req_o, col_rsp_valid_o}, 2'b00);
    cyc();
    obi_rvalid_i = 0;
    check("t1_rsp", {col_rsp_valid_o, col_rsp_err_o, col_rsp_rdata_o}, {2'b10, 32'hDEAD_BEEF});
    cyc();
    check("t1_idle", {col_rsp_valid_o, busy_o}, 2'b00);
    // write with grant withheld five cycles
    col_req_valid_i = 1; col_req_we_i = 1; col_req_be_i = 4'b0011;
    col_req_addr_i = 32'h200; col_req_wdata_i = 32'h1234_5678;
    cyc();
    col_req_valid_i = 0;
    for (int i = 0; i < 6; i++) begin
      check("t2_hold", {obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, col_req_ready_o},
            {1'b1, 32'h200, 1'b1, 4'b0011, 32'h1234_5678, 1'b0});
      if (i == 5) obi_gnt_i = 1;
      cyc();
    end
    obi_gnt_i = 0;
    check("t2_released", obi_req_o, 0);
    obi_rvalid_i = 1; obi_rdata_i = 0;
    cyc();
    obi_rvalid_i = 0;
    check("t2_rsp", {col_rsp_valid_o, col_rsp_err_o, col_rsp_rdata_o}, {2'b10, 32'h0});
    cyc();
    // three reads with the response side stalled
    col_rsp_ready_i = 0; auto_sl = 1; gnt_pct = 100; rv_pct = 100;
    g0 = n_grant; a0 = n_acc; idx = 0;
    col_req_valid_i = 1; col_req_we_i = 0; col_req_addr_i = 32'h110;
    t3_run(12);
    check("t3_issued", n_grant - g0, 2);
    check("t3_accepted", n_acc - a0, 2);
    check("t3_stall", {col_req_ready_o, col_req_valid_i}, 2'b01);
    col_rsp_ready_i = 1;
    t3_run(1);
    col_rsp_ready_i = 0;
    t3_run(8);
    check("t3_third_issued", n_grant - g0, 3);
    col_rsp_ready_i = 1;
    repeat (6) cyc();
    auto_sl = 0; obi_gnt_i = 0; obi_rvalid_i = 0;
    check("t3_drained", {exp_err.size() == 0, busy_o}, 2'b10);
    // out-of-window read behind an outstanding read
    col_req_valid_i = 1; col_req_addr_i = 32'h200; obi_gnt_i = 1;
    cyc();
    col_req_valid_i = 0;
    cyc();
    obi_gnt_i = 0; col_req_valid_i = 1; col_req_addr_i = 32'h0010_0000;
    check("t4_ready", col_req_ready_o, 1);
    cyc();
    col_req_valid_i = 0;
    repeat (3) begin
      check("t4_wait", {obi_req_o, col_rsp_valid_o, busy_o}, 3'b001);
      cyc();
    end
    obi_rvalid_i = 1; obi_rdata_i = 32'hCAFE_F00D;
    cyc();
    obi_rvalid_i = 0;
    check("t4_first", {col_rsp_valid_o, col_rsp_err_o, col_rsp_rdata_o}, {2'b10, 32'hCAFE_F00D});
    cyc();
    check("t4_err", {col_rsp_valid_o, col_rsp_err_o, col_rsp_rdata_o}, {2'b11, 32'h0});
    cyc();
    check("t4_idle", {col_rsp_valid_o, busy_o}, 2'b00);
    // spurious rvalid
    obi_rvalid_i = 1; obi_rdata_i = 32'h55;
    repeat (3) begin
      cyc();
      check("t5_spurious", {busy_o, col_rsp_valid_o}, 2'b00);
    end
    obi_rvalid_i = 0;
    // reset while requesting with one read outstanding
    col_req_valid_i = 1; col_req_addr_i = 32'h300; obi_gnt_i = 1;
    cyc();
    col_req_valid_i = 0;
    cyc();
    obi_gnt_i = 0; col_req_valid_i = 1; col_req_addr_i = 32'h304;
    cyc();
    col_req_valid_i = 0;
    check("t6_req", obi_req_o, 1);
    rst_i = 1;
    cyc();
    check("t6_reset_outputs", all_outs(), 0);
    rst_i = 0;
    #1;
    check("t6_ready", col_req_ready_o, 1);
    // randomized traffic
    auto_sl = 1; gnt_pct = 60; rv_pct = 50; rnd_req = 1;
    a0 = n_acc;
    repeat (3000) cyc();
    rnd_req = 0; col_req_valid_i = 0; col_rsp_ready_i = 1;
    for (int i = 0; i < 200 && (busy_o || exp_err.size() != 0); i++) cyc();
    check("rnd_activity", n_acc - a0 > 300, 1);
    check("rnd_drain_queue", exp_err.size(), 0);
    check("rnd_drain_busy", busy_o, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
